// File: rtl/key_request_capture.sv
// rtl/key_request_capture.sv - debounced key lines latched into a request vector with sticky drop flags
module key_request_capture #(
  parameter int TICK_DIV = 100000,
  parameter int DB_TICKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] raw_in,
  input  logic        ack,
  input  logic [3:0]  ack_idx,
  output logic [15:0] pending,
  output logic        any_pending,
  output logic [15:0] dropped
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_MAX   = 4'(DB_TICKS - 1);

  logic [15:0]   sync1;
  logic [15:0]   sync;
  logic [15:0]   db;
  logic [3:0]    cnt [16];
  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   differ;
  logic [15:0]   expire;
  logic [15:0]   rise;
  logic [15:0]   clr;

  assign tick        = (presc == PRESC_MAX);
  assign rise        = expire & sync;
  assign clr         = ack ? (16'h0001 << ack_idx) : 16'h0000;
  assign any_pending = |pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync  <= '0;
    end else begin
      sync1 <= raw_in;
      sync  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tick) presc <= '0;
    else             presc <= presc + 1'b1;
  end

  // A bit expires when it has disagreed with db for DB_TICKS consecutive ticks
  always_comb begin
    differ = sync ^ db;
    expire = '0;
    for (int i = 0; i < 16; i++) begin
      expire[i] = differ[i] && tick && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      db <= db ^ expire;
      for (int i = 0; i < 16; i++) begin
        if (!differ[i] || expire[i]) cnt[i] <= '0;
        else if (tick)               cnt[i] <= cnt[i] + 4'd1;
      end
    end
  end

  // Set beats a same-cycle ack so a fresh press is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      dropped <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      dropped <= dropped | (rise & pending & ~clr);
    end
  end

endmodule

// File: tb/tb_key_request_capture.sv
// tb/tb_key_request_capture.sv - scoreboard bench for key_request_capture
module tb_key_request_capture;

  localparam int TICK_DIV = 4;
  localparam int DB_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] raw_in;
  logic        ack;
  logic [3:0]  ack_idx;
  logic [15:0] pending;
  logic        any_pending;
  logic [15:0] dropped;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  key_request_capture #(.TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .ack(ack),
    .ack_idx(ack_idx),
    .pending(pending),
    .any_pending(any_pending),
    .dropped(dropped)
  );

  // Returns at the negedge after the first edge that shows a masked pending bit
  task automatic wait_pending(input logic [15:0] mask, input int budget,
                              output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((pending & mask) != 16'h0000) begin
        seen = 1'b1;
        lat  = k;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ack = 1'b0; ack_idx = 4'd0; raw_in = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_ack(input logic [3:0] idx);
    ack = 1'b1; ack_idx = idx;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ack = 1'b0; ack_idx = 4'd0; raw_in = 16'hffff;
    repeat (2) @(negedge clk);
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL reset_pending got %h want 0000", pending); end
    vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL reset_any got %b want 0", any_pending); end
    vectors++; if (dropped !== 16'h0000) begin miscompares++; $display("FAIL reset_dropped got %h want 0000", dropped); end
  endtask

  task automatic test_press_latency();
    int lat; bit seen; logic [15:0] exp;
    do_reset();
    raw_in[5] = 1'b1;
    exp_q.push_back(16'h0020);
    wait_pending(16'hffff, 30, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL press_timeout got none want %h", exp); end
    else begin
      vectors++; if (pending !== exp) begin miscompares++; $display("FAIL press_value got %h want %h", pending, exp); end
      vectors++; if (lat < 10 || lat > 15) begin miscompares++; $display("FAIL press_latency got %0d want 10..15", lat); end
      vectors++; if (any_pending !== 1'b1) begin miscompares++; $display("FAIL press_any got %b want 1", any_pending); end
    end
  endtask

  task automatic test_ack();
    do_ack(4'd5);
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL ack_clear got %h want 0000", pending); end
    vectors++; if (any_pending !== 1'b0) begin miscompares++; $display("FAIL ack_any got %b want 0", any_pending); end
    do_ack(4'd5);
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL ack_repeat got %h want 0000", pending); end
    vectors++; if (dropped !== 16'h0000) begin miscompares++; $display("FAIL ack_repeat_dropped got %h want 0000", dropped); end
  endtask

  task automatic test_glitch();
    int bad;
    do_reset();
    raw_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    raw_in[3] = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      vectors++;
      if (pending !== 16'h0000 || dropped !== 16'h0000) begin
        miscompares++;
        if (bad == 0) $display("FAIL glitch cycle %0d got pending %h dropped %h want 0000", k, pending, dropped);
        bad++;
      end
    end
  endtask

  task automatic test_dropped();
    int lat; bit seen; logic [15:0] exp;
    do_reset();
    raw_in[7] = 1'b1;
    exp_q.push_back(16'h0080);
    wait_pending(16'hffff, 30, lat, seen);
    exp = exp_q.pop_front();
    vectors++; if (!seen || pending !== exp) begin miscompares++; $display("FAIL drop_first got %h want %h", pending, exp); end
    raw_in[7] = 1'b0;
    repeat (20) @(negedge clk);
    vectors++; if (pending !== 16'h0080) begin miscompares++; $display("FAIL release_keeps got %h want 0080", pending); end
    raw_in[7] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (dropped != 16'h0000) seen = 1'b1;
    end
    vectors++; if (dropped !== 16'h0080) begin miscompares++; $display("FAIL drop_flag got %h want 0080", dropped); end
    vectors++; if (pending !== 16'h0080) begin miscompares++; $display("FAIL drop_pending got %h want 0080", pending); end
    do_ack(4'd7);
    repeat (10) @(negedge clk);
    vectors++; if (pending !== 16'h0000) begin miscompares++; $display("FAIL drop_ack got %h want 0000", pending); end
    vectors++; if (dropped !== 16'h0080) begin miscompares++; $display("FAIL drop_sticky got %h want 0080", dropped); end
    do_reset();
    vectors++; if (dropped !== 16'h0000) begin miscompares++; $display("FAIL drop_reset got %h want 0000", dropped); end
  endtask

  task automatic test_collision();
    int lat; bit seen; logic [15:0] exp;
    do_reset();
    raw_in[2] = 1'b1;
    ack = 1'b1; ack_idx = 4'd2;
    exp_q.push_back(16'h0004);
    wait_pending(16'h0004, 30, lat, seen);
    ack = 1'b0;
    exp = exp_q.pop_front();
    vectors++; if (!seen) begin miscompares++; $display("FAIL collide_set got %h want %h", pending, exp); end
    @(negedge clk);
    vectors++; if (pending !== exp) begin miscompares++; $display("FAIL collide_hold got %h want %h", pending, exp); end
    vectors++; if (dropped !== 16'h0000) begin miscompares++; $display("FAIL collide_dropped got %h want 0000", dropped); end
  endtask

  task automatic test_reset_mid();
    int lat; bit seen; logic [15:0] exp;
    do_reset();
    raw_in[9] = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (pending !== 16'h0000 || dropped !== 16'h0000 || any_pending !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs got %h %h %b want 0000 0000 0", pending, dropped, any_pending);
    end
    rst = 1'b0;
    exp_q.push_back(16'h0200);
    wait_pending(16'hffff, 30, lat, seen);
    exp = exp_q.pop_front();
    vectors++; if (!seen || pending !== exp) begin miscompares++; $display("FAIL midrst_value got %h want %h", pending, exp); end
    vectors++; if (lat < 10) begin miscompares++; $display("FAIL midrst_latency got %0d want >=10", lat); end
  endtask

  task automatic test_multi();
    int lat; bit seen; logic [15:0] exp;
    do_reset();
    raw_in = 16'h1002;
    exp_q.push_back(16'h1002);
    wait_pending(16'hffff, 30, lat, seen);
    exp = exp_q.pop_front();
    vectors++; if (!seen || pending !== exp) begin miscompares++; $display("FAIL multi_set got %h want %h", pending, exp); end
    do_ack(4'd0);
    vectors++; if (pending !== 16'h1002 || dropped !== 16'h0000) begin
      miscompares++; $display("FAIL ack_idle_bit got %h %h want 1002 0000", pending, dropped);
    end
    do_ack(4'd12);
    vectors++; if (pending !== 16'h0002) begin miscompares++; $display("FAIL multi_ack got %h want 0002", pending); end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_ack();
    test_glitch();
    test_dropped();
    test_collision();
    test_reset_mid();
    test_multi();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
